up_dp_param: RTL and testbench

Parametrised accumulator-machine datapath. It is the next generation of the 8-bit/32-word datapath and is driven cycle by cycle by the external control FSM.
- Adds configurable data and address widths.
- Adds a hardware stack pointer for CALL/RET.
- Adds carry-chained ALU operations with C/V flags.
- Adds a registered output port.
- Contains the IR, A, PC, SP, flag and OUT registers and a 2^AW x DW RAM.

---
 rtl/up_dp_param.sv | 78 +++++++
 tb/tb_up_dp_param.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/up_dp_param.sv
// up_dp_param: parametrised accumulator datapath with IR, A, PC, SP, C/V flags, output register and 2^AW x DW RAM
module up_dp_param #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [DW-1:0]    Input,
  input  logic             IRload,
  input  logic             PCload,
  input  logic [1:0]       PCsel,
  input  logic [1:0]       Msel,
  input  logic             MemWr,
  input  logic             Wsel,
  input  logic             Aload,
  input  logic [1:0]       Asel,
  input  logic [1:0]       ALUop,
  input  logic [1:0]       SPop,
  input  logic             Outload,
  output logic             Aeq0,
  output logic             Apos,
  output logic             Cflag,
  output logic             Vflag,
  output logic [DW-AW-1:0] IR,
  output logic [DW-1:0]    Output
);
  localparam int OPW = DW - AW;
  logic [DW-1:0] instr, a, m, b, res, wdata, a_next;
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] pc, sp, addr, pc_inc, sp_inc, sp_dec, pc_next, sp_next;
  logic [DW:0]   sum;
  logic          c, v, cin, v_next;
  always_comb begin
    pc_inc  = pc + 1'b1;
    sp_inc  = sp + 1'b1;
    sp_dec  = sp - 1'b1;
    addr    = Msel == 2'b00 ? pc : Msel == 2'b01 ? instr[AW-1:0] : Msel == 2'b10 ? sp : sp_inc;
    m       = mem[addr];
    b       = ALUop[0] ? ~m : m;
    cin     = ALUop[1] ? c : ALUop[0];
    sum     = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
    res     = sum[DW-1:0];
    v_next  = (a[DW-1] == b[DW-1]) && (res[DW-1] != a[DW-1]);
    wdata   = Wsel ? {{OPW{1'b0}}, pc_inc} : a;
    pc_next = PCsel == 2'b00 ? pc_inc : PCsel == 2'b01 ? instr[AW-1:0] : PCsel == 2'b10 ? m[AW-1:0] : pc;
    sp_next = SPop == 2'b01 ? sp_dec : SPop == 2'b10 ? sp_inc : sp;
    a_next  = Asel == 2'b00 ? res : Asel == 2'b01 ? Input : Asel == 2'b10 ? m : a;
  end
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      instr  <= '0;
      a      <= '0;
      pc     <= '0;
      sp     <= '1;
      c      <= 1'b0;
      v      <= 1'b0;
      Output <= '0;
    end else begin
      if (IRload) instr <= m;
      if (PCload) pc <= pc_next;
      sp <= sp_next;
      if (Aload) a <= a_next;
      if (Aload && Asel == 2'b00) begin
        c <= sum[DW];
        v <= v_next;
      end
      if (Outload) Output <= a;
    end
  end
  always_ff @(posedge CLOCK) begin
    if (MemWr) mem[addr] <= wdata;
  end
  assign Aeq0  = a == '0;
  assign Apos  = ~a[DW-1];
  assign Cflag = c;
  assign Vflag = v;
  assign IR    = instr[DW-1:AW];
endmodule

// File: tb/tb_up_dp_param.sv
// tb_up_dp_param: directed and random checks of up_dp_param against an arithmetic reference model
module tb_up_dp_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [7:0] in8, out8;
  logic ir_ld, pc_ld, mem_wr, wsel, a_ld, out_ld;
  logic [1:0] pcsel, msel, asel, aluop, spop;
  logic aeq0, apos, cf, vf;
  logic [2:0] ir8;
  logic [15:0] in16, out16;
  logic a_ld16, out_ld16;
  logic [1:0] asel16;
  logic aeq0_16, apos16, cf16, vf16;
  logic [7:0] ir16;
  up_dp_param #(.DW(8), .AW(5)) dut8 (
    .CLOCK(clk), .RESET(rst), .Input(in8), .IRload(ir_ld), .PCload(pc_ld), .PCsel(pcsel),
    .Msel(msel), .MemWr(mem_wr), .Wsel(wsel), .Aload(a_ld), .Asel(asel), .ALUop(aluop),
    .SPop(spop), .Outload(out_ld), .Aeq0(aeq0), .Apos(apos), .Cflag(cf), .Vflag(vf),
    .IR(ir8), .Output(out8)
  );
  up_dp_param #(.DW(16), .AW(8)) dut16 (
    .CLOCK(clk), .RESET(rst), .Input(in16), .IRload(1'b0), .PCload(1'b0), .PCsel(2'b11),
    .Msel(2'b00), .MemWr(1'b0), .Wsel(1'b0), .Aload(a_ld16), .Asel(asel16), .ALUop(2'b00),
    .SPop(2'b00), .Outload(out_ld16), .Aeq0(aeq0_16), .Apos(apos16), .Cflag(cf16), .Vflag(vf16),
    .IR(ir16), .Output(out16)
  );
  int checks = 0, errors = 0;
  int ma, mpc, msp, mc, mv, mir, mout;
  int mmem [32];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int sx(input int x);
    return x > 127 ? x - 256 : x;
  endfunction
  task automatic model_reset();
    ma = 0; mpc = 0; msp = 31; mc = 0; mv = 0; mir = 0; mout = 0;
  endtask
  task automatic idle();
    ir_ld = 0; pc_ld = 0; mem_wr = 0; wsel = 0; a_ld = 0; out_ld = 0;
    pcsel = 2'b11; msel = 2'b00; asel = 2'b11; aluop = 2'b00; spop = 2'b00;
  endtask
  task automatic check_all();
    chk("A", 32'(dut8.a), ma);
    chk("Aeq0", 32'(aeq0), 32'(ma == 0));
    chk("Apos", 32'(apos), 32'(ma < 128));
    chk("C", 32'(cf), mc);
    chk("V", 32'(vf), mv);
    chk("IR", 32'(ir8), mir >> 5);
    chk("Output", 32'(out8), mout);
    chk("PC", 32'(dut8.pc), mpc);
    chk("SP", 32'(dut8.sp), msp);
  endtask
  // Predict the edge from the model's rules, clock once, then compare everything.
  task automatic tick();
    int addr, mm, full, sfull, res, wd, npc, nsp, na, nc, nv, nout, nir;
    addr = msel == 0 ? mpc : msel == 1 ? mir % 32 : msel == 2 ? msp : (msp + 1) % 32;
    mm = mmem[addr];
    case (aluop)
      2'd0: begin full = ma + mm; sfull = sx(ma) + sx(mm); end
      2'd1: begin full = ma - mm; sfull = sx(ma) - sx(mm); end
      2'd2: begin full = ma + mm + mc; sfull = sx(ma) + sx(mm) + mc; end
      default: begin full = ma - mm - (1 - mc); sfull = sx(ma) - sx(mm) - (1 - mc); end
    endcase
    res = full & 255;
    nc = aluop[0] ? int'(full >= 0) : int'(full > 255);
    nv = int'(sfull > 127 || sfull < -128);
    wd = wsel ? (mpc + 1) % 32 : ma;
    npc = !pc_ld ? mpc : pcsel == 0 ? (mpc + 1) % 32 : pcsel == 1 ? mir % 32 : pcsel == 2 ? mm % 32 : mpc;
    nsp = spop == 1 ? (msp + 31) % 32 : spop == 2 ? (msp + 1) % 32 : msp;
    na = !a_ld ? ma : asel == 0 ? res : asel == 1 ? int'(in8) : asel == 2 ? mm : ma;
    nout = out_ld ? ma : mout;
    nir = ir_ld ? mm : mir;
    @(posedge clk);
    #1;
    if (a_ld && asel == 0) begin mc = nc; mv = nv; end
    if (mem_wr) mmem[addr] = wd;
    ma = na; mpc = npc; msp = nsp; mout = nout; mir = nir;
    check_all();
    if (mem_wr) chk("MEM", 32'(dut8.mem[addr]), mmem[addr]);
  endtask
  task automatic load_a(input logic [7:0] val);
    idle(); in8 = val; asel = 2'b01; a_ld = 1; tick();
  endtask
  task automatic put_m(input logic [7:0] val);
    load_a(val);
    idle(); msel = 2'b10; mem_wr = 1; tick();
  endtask
  task automatic alu(input logic [1:0] op);
    idle(); msel = 2'b10; aluop = op; asel = 2'b00; a_ld = 1; tick();
  endtask
  initial begin
    int old5, oc, ov;
    rst = 1; idle(); in8 = 0; in16 = 0; a_ld16 = 0; asel16 = 2'b11; out_ld16 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("out16_reset", 32'(out16), 0);
    rst = 0;
    for (int i = 0; i < 32; i++) begin
      load_a(i == 0 ? 8'hA3 : 8'($urandom_range(0, 255)));
      idle(); mem_wr = 1; pc_ld = 1; pcsel = 2'b00; tick();
    end
    chk("pc_wrap_fill", 32'(dut8.pc), 0);
    idle(); ir_ld = 1; tick();
    idle(); pc_ld = 1; pcsel = 2'b00; tick();
    rst = 1;
    #2;
    model_reset();
    check_all();
    idle(); ir_ld = 1; pc_ld = 1; pcsel = 2'b00; spop = 2'b01; a_ld = 1; asel = 2'b01; in8 = 8'h55; out_ld = 1;
    @(posedge clk);
    #1;
    check_all();
    rst = 0;
    idle(); ir_ld = 1; tick();
    chk("fetch_ir", 32'(ir8), 5);
    chk("fetch_pc", 32'(dut8.pc), 0);
    chk("fetch_sp", 32'(dut8.sp), 31);
    chk("fetch_out", 32'(out8), 0);
    put_m(8'h01); load_a(8'hFF); alu(2'b00);
    chk("add_a", 32'(dut8.a), 0);
    chk("add_aeq0", 32'(aeq0), 1);
    chk("add_c", 32'(cf), 1);
    chk("add_v", 32'(vf), 0);
    idle(); msel = 2'b10; mem_wr = 1; tick();
    alu(2'b10);
    chk("addc_a", 32'(dut8.a), 1);
    chk("addc_c", 32'(cf), 0);
    put_m(8'h01); load_a(8'h7F); alu(2'b00);
    chk("ovf_a", 32'(dut8.a), 32'h80);
    chk("ovf_v", 32'(vf), 1);
    chk("ovf_apos", 32'(apos), 0);
    put_m(8'h07); load_a(8'h05); alu(2'b01);
    chk("sub_a", 32'(dut8.a), 32'hFE);
    chk("sub_c", 32'(cf), 0);
    chk("sub_v", 32'(vf), 0);
    rst = 1; #1; rst = 0; model_reset();
    check_all();
    put_m(8'h6A);
    idle(); msel = 2'b10; ir_ld = 1; tick();
    repeat (4) begin idle(); pc_ld = 1; pcsel = 2'b00; tick(); end
    idle(); msel = 2'b10; wsel = 1; mem_wr = 1; spop = 2'b01; pcsel = 2'b01; pc_ld = 1; tick();
    chk("call_mem31", 32'(dut8.mem[31]), 5);
    chk("call_sp", 32'(dut8.sp), 32'h1E);
    chk("call_pc", 32'(dut8.pc), 32'h0A);
    idle(); msel = 2'b11; pcsel = 2'b10; pc_ld = 1; spop = 2'b10; tick();
    chk("ret_pc", 32'(dut8.pc), 5);
    chk("ret_sp", 32'(dut8.sp), 32'h1F);
    put_m(8'hE5);
    idle(); msel = 2'b10; ir_ld = 1; tick();
    load_a(8'h3C);
    for (int k = 0; k < 32 && mpc != 31; k++) begin idle(); pc_ld = 1; pcsel = 2'b00; tick(); end
    for (int k = 0; k < 32 && msp != 0; k++) begin idle(); spop = 2'b01; tick(); end
    old5 = mmem[5];
    idle(); pc_ld = 1; pcsel = 2'b00; spop = 2'b01; msel = 2'b01; mem_wr = 1; asel = 2'b10; a_ld = 1; tick();
    chk("wrap_pc", 32'(dut8.pc), 0);
    chk("wrap_sp", 32'(dut8.sp), 32'h1F);
    chk("wrap_old_read", 32'(dut8.a), old5);
    chk("wrap_mem5", 32'(dut8.mem[5]), 32'h3C);
    in16 = 16'h1234; a_ld16 = 1; asel16 = 2'b01;
    load_a(8'h11);
    oc = mc; ov = mv;
    idle(); in8 = 8'h22; asel = 2'b01; a_ld = 1; out_ld = 1;
    in16 = 16'hABCD; out_ld16 = 1;
    tick();
    a_ld16 = 0; out_ld16 = 0;
    chk("sim_out", 32'(out8), 32'h11);
    chk("sim_a", 32'(dut8.a), 32'h22);
    chk("sim_c", 32'(cf), oc);
    chk("sim_v", 32'(vf), ov);
    chk("sim16_out", 32'(out16), 32'h1234);
    chk("sim16_a", 32'(dut16.a), 32'hABCD);
    chk("sim16_c", 32'(cf16), 0);
    chk("sim16_v", 32'(vf16), 0);
    chk("sim16_apos", 32'(apos16), 0);
    repeat (400) begin
      ir_ld = 1'($urandom); pc_ld = 1'($urandom); mem_wr = 1'($urandom); wsel = 1'($urandom);
      a_ld = 1'($urandom); out_ld = 1'($urandom); pcsel = 2'($urandom); msel = 2'($urandom);
      asel = 2'($urandom); aluop = 2'($urandom); spop = 2'($urandom); in8 = 8'($urandom);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
